// File: rtl/rr_data_arbiter.sv
// rr_data_arbiter
// Round-robin arbiter that shares a single registered output byte between
// NUM_REQ requesters. Each requester offers a byte with a valid/ready
// handshake. The arbiter grants one requester at a time, latches its byte,
// and presents it downstream with its own valid/ready handshake. A
// wrapping counter records completed downstream transfers.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   enable       permits new grants when high
//   req_valid    per-requester offer valid
//   req_data     requester i occupies bits [i*DATA_W +: DATA_W]
//   req_ready    one-hot (or zero) combinational accept strobe
//   out_valid    held byte available downstream
//   out_data     held byte
//   out_src      index of the requester whose byte is held
//   out_ready    downstream accept
//   grant_count  completed downstream transfers, wrapping
//   busy         high while a byte is held
module rr_data_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          grant_count,
    output logic                      busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SRC_W-1:0]  ptr_q;
    logic [SRC_W-1:0]  next_ptr;
    logic [SRC_W-1:0]  scan_ptr;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  cand;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;
    logic [CNT_W-1:0]  count_q;
    logic              found;
    logic              completion;
    logic              open_win;
    logic              capture;
    int                cand_i;

    logic [DATA_W-1:0] req_bytes [NUM_REQ];

    // Split the flat data bus into one byte lane per requester so the
    // winner's byte can be picked by a plain array index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lanes
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    // A held byte leaves when downstream accepts it. The accept window
    // opens either from IDLE or in the same cycle a held byte completes,
    // which is what allows one transfer per cycle at full rate.
    assign completion = (state_q == HOLD) && out_ready;
    assign open_win   = enable && ((state_q == IDLE) || completion);

    // Pointer value after a completion: one past the requester just served,
    // wrapping back to zero after the last requester.
    always_comb begin
        next_ptr = '0;
        if (int'(out_src_q) != NUM_REQ - 1) begin
            next_ptr = out_src_q + 1'b1;
        end
    end

    // The scan starts from the post-update pointer, so a completing
    // requester is pushed to the back of the queue in the same cycle.
    assign scan_ptr = completion ? next_ptr : ptr_q;

    // Find the first asserted req_valid at or above scan_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        cand_i = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = int'(scan_ptr) + k;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            cand = SRC_W'(cand_i);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Reset masks the strobe so nothing is accepted during reset.
    assign capture = open_win && found && !reset;

    always_comb begin
        req_ready = '0;
        if (capture) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic: a capture always lands in HOLD (including
    // back-to-back with a completion); a completion alone returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = HOLD;
        end else if (completion) begin
            state_d = IDLE;
        end
    end

    // State, datapath and counter registers. The pointer moves only on
    // completion, never on capture alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (completion) begin
                count_q <= count_q + 1'b1;
                ptr_q   <= next_ptr;
            end
            if (capture) begin
                out_data_q <= req_bytes[winner];
                out_src_q  <= winner;
            end
        end
    end

    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q == HOLD);
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign grant_count = count_q;

endmodule

// File: tb/tb_rr_data_arbiter.sv
// tb_rr_data_arbiter
// Directed testbench for rr_data_arbiter with NUM_REQ=4, DATA_W=8 and a
// 4-bit transfer counter so that wrap-around is reachable quickly. Each
// task drives one scenario and checks hand-computed expected values.
module tb_rr_data_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [3:0]  grant_count;
    logic        busy;

    int checks = 0;
    int passes = 0;

    rr_data_arbiter #(
        .NUM_REQ(4),
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .grant_count(grant_count),
        .busy       (busy)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held two cycles with every requester asking for service.
    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_data !== 8'h00) $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); else passes++;
        checks++; if (grant_count !== 4'd0) $display("[TB] FAIL reset_grant_count: got %0d expected 0", grant_count); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        reset     = 1'b0;
        req_valid = 4'b0000;
    endtask

    // One requester, one byte, one-cycle latency to the output.
    task automatic test_single();
        enable          = 1'b1;
        out_ready       = 1'b1;
        req_data[15:8]  = 8'hA5;
        req_valid       = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL single_req_ready: got %b expected 0010", req_ready); else passes++;
        tick();
        req_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL single_out_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_data !== 8'hA5) $display("[TB] FAIL single_out_data: got %h expected a5", out_data); else passes++;
        checks++; if (out_src !== 2'd1) $display("[TB] FAIL single_out_src: got %0d expected 1", out_src); else passes++;
        checks++; if (grant_count !== 4'd0) $display("[TB] FAIL single_count_before: got %0d expected 0", grant_count); else passes++;
        tick();
        checks++; if (grant_count !== 4'd1) $display("[TB] FAIL single_count_after: got %0d expected 1", grant_count); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_idle: got %b expected 0", out_valid); else passes++;
    endtask

    // All four requesting at full rate after a fresh reset: 0,1,2,3,0,1.
    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [1:0] exp_src;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        req_data  = 32'h13121110;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_src   = 2'(k % 4);
            exp_ready = 4'b0001 << exp_src;
            #1;
            checks++; if (req_ready !== exp_ready) $display("[TB] FAIL rr_req_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); else passes++;
            tick();
            checks++; if (out_src !== exp_src) $display("[TB] FAIL rr_out_src[%0d]: got %0d expected %0d", k, out_src, exp_src); else passes++;
            checks++; if (out_data !== (8'h10 + 8'(exp_src))) $display("[TB] FAIL rr_out_data[%0d]: got %h expected %h", k, out_data, 8'h10 + 8'(exp_src)); else passes++;
        end
        checks++; if (grant_count !== 4'd5) $display("[TB] FAIL rr_count: got %0d expected 5", grant_count); else passes++;
        req_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rr_drain: got %b expected 0", out_valid); else passes++;
    endtask

    // Hold req2's byte under backpressure, then release; req3 wins next.
    task automatic test_backpressure();
        req_data[23:16] = 8'h3C;
        req_data[31:24] = 8'h77;
        req_valid       = 4'b0100;
        out_ready       = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL bp_capture: got %b expected 0100", req_ready); else passes++;
        tick();
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_req_ready[%0d]: got %b expected 0000", k, req_ready); else passes++;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) $display("[TB] FAIL bp_hold[%0d]: got %b/%h expected 1/3c", k, out_valid, out_data); else passes++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL bp_b2b_ready: got %b expected 1000", req_ready); else passes++;
        tick();
        checks++; if (out_src !== 2'd3 || out_data !== 8'h77) $display("[TB] FAIL bp_next: got %0d/%h expected 3/77", out_src, out_data); else passes++;
        checks++; if (grant_count !== 4'd7) $display("[TB] FAIL bp_count: got %0d expected 7", grant_count); else passes++;
        req_valid = 4'b0000;
        tick();
        checks++; if (grant_count !== 4'd8 || busy !== 1'b0) $display("[TB] FAIL bp_drain: got %0d/%b expected 8/0", grant_count, busy); else passes++;
    endtask

    // enable low blocks new grants but lets a held byte finish.
    task automatic test_enable();
        enable    = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b0) $display("[TB] FAIL en_gate[%0d]: got %b/%b expected 0000/0", k, req_ready, out_valid); else passes++;
            tick();
        end
        enable    = 1'b1;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL en_grant: got %b expected 0001", req_ready); else passes++;
        tick();
        enable    = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'b1111;
        tick();
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL en_held: got %b/%b expected 1/1", out_valid, busy); else passes++;
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL en_no_b2b: got %b expected 0000", req_ready); else passes++;
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("[TB] FAIL en_idle: got %b/%b expected 0/0", busy, out_valid); else passes++;
        checks++; if (grant_count !== 4'd9) $display("[TB] FAIL en_count: got %0d expected 9", grant_count); else passes++;
    endtask

    // Reset while holding req2's byte; afterwards req0 is first in line.
    task automatic test_reset_mid();
        enable    = 1'b1;
        out_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd2) $display("[TB] FAIL rm_hold: got %b/%0d expected 1/2", out_valid, out_src); else passes++;
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL rm_ready_in_reset: got %b expected 0000", req_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0 || grant_count !== 4'd0 || busy !== 1'b0) $display("[TB] FAIL rm_cleared: got %b/%0d/%b expected 0/0/0", out_valid, grant_count, busy); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL rm_first: got %b expected 0001", req_ready); else passes++;
        tick();
        checks++; if (out_src !== 2'd0) $display("[TB] FAIL rm_src: got %0d expected 0", out_src); else passes++;
    endtask

    // 17 completions on a 4-bit counter: reads 0 after 16, 1 after 17.
    task automatic test_counter_wrap();
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 16) begin
                checks++; if (grant_count !== 4'd0) $display("[TB] FAIL wrap_16: got %0d expected 0", grant_count); else passes++;
            end
        end
        checks++; if (grant_count !== 4'd1) $display("[TB] FAIL wrap_17: got %0d expected 1", grant_count); else passes++;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_data_arbiter.md
Name: rr_data_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered 8-bit output datapath between NUM_REQ requesters.
- Each requester offers a byte with a valid/ready handshake. The block grants one requester at a time, latches its byte, and presents it downstream with a valid/ready handshake.
- A global enable gates new grants, and a wrapping counter records completed transfers.

Parameters:
- NUM_REQ, 4: number of requesters (>= 2).
- DATA_W, 8: data width.
- CNT_W, 16: width of the completed-transfer counter.
- SRC_W, $clog2(NUM_REQ): width of the source index (derived; do not override).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits new grants when high.
- req_valid  input  NUM_REQ  per-requester offer valid.
- req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot (or zero) accept strobe, combinational.
- out_valid  output  1  held byte available downstream.
- out_data  output  DATA_W  held byte.
- out_src  output  SRC_W  index of the requester whose byte is held.
- out_ready  input  1  downstream accept.
- grant_count  output  CNT_W  completed downstream transfers, wrapping.
- busy  output  1  high while a byte is held (state HOLD).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, out_valid 0, out_data 0, out_src 0, rr pointer 0, grant_count 0, busy 0, req_ready all 0.
- State IDLE: out_valid=0.
- State HOLD: out_valid=1; out_data and out_src are stable until accepted.
- Accept window:
  - open = enable && (state==IDLE || (state==HOLD && out_ready)).
  - When open and any req_valid is high, the winner is the first set req_valid scanning from index ptr upward, wrapping NUM_REQ-1 -> 0.
  - ptr is the post-update pointer: if a completion happens this cycle, the scan starts from out_src+1.
  - req_ready[winner]=1 in that cycle only; all other bits are 0.
- Capture: on the winner's handshake, out_data<=req_data[winner], out_src<=winner, next state HOLD.
  - Latency: a byte accepted in cycle N is presented on out_valid/out_data in cycle N+1.
- Completion (HOLD && out_ready):
  - grant_count<=grant_count+1, wrapping modulo 2^CNT_W.
  - ptr<=(out_src+1) mod NUM_REQ.
  - If no new capture happens in the same cycle, next state is IDLE.
  - Back-to-back transfers are allowed: completion and a new capture in the same cycle give state HOLD and one transfer per cycle.
- Pointer rule: ptr changes only on completion, never on capture alone.
- Fairness: a requester holding req_valid continuously is served within NUM_REQ completions.
- enable low:
  - req_ready is all 0 and no new capture occurs.
  - An item already held stays in HOLD and completes normally on out_ready.
  - The state then goes IDLE.
- Requesters: may drop req_valid without a handshake. The arbiter places no constraint on requesters.
- Downstream: out_valid is never retracted before out_ready.
- Reset mid-HOLD: the held byte is discarded; out_valid=0 in the next cycle; ptr=0; grant_count=0.
- Reset has priority over every other event in the same cycle. req_ready is 0 while reset is high.
- busy equals (state==HOLD), registered.

Test Plan:
- Reset: hold reset 2 cycles with all req_valid=1 -> req_ready=0000, out_valid=0, out_data=0x00, grant_count=0, busy=0.
- Single request:
  - Stimulus: enable=1, req_valid=0010, req1 data=0xA5, out_ready=1.
  - Response: req_ready=0010 in cycle N; cycle N+1 out_valid=1, out_data=0xA5, out_src=1; grant_count=1 after cycle N+1.
- Round robin at full rate:
  - Stimulus: req_valid=1111 continuously, data i=0x10+i, out_ready=1.
  - Response: out_src sequence 0,1,2,3,0,1 on consecutive cycles; out_data 0x10,0x11,0x12,0x13,0x10; one req_ready per cycle.
- Backpressure:
  - Stimulus: capture req2 data 0x3C, then out_ready=0 for 5 cycles.
  - Response: out_valid=1 and out_data=0x3C stable; req_ready=0000 throughout.
  - Then out_ready=1 -> completion; req3 (valid) is granted in the same cycle.
- Enable gating:
  - Stimulus: enable=0 with req_valid=1111 -> no req_ready for 10 cycles, out_valid=0.
  - Stimulus: drop enable during HOLD -> the held byte still completes, then state IDLE and busy=0.
- Reset mid-operation and counter wrap:
  - Stimulus: reset asserted in HOLD -> next cycle out_valid=0, grant_count=0; afterwards req0 is granted first.
  - Stimulus: with CNT_W=4, 17 completions -> grant_count reads 1.
